// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, port index type and funct3 access widths for mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic port_t;
  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HALF   = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] BYTE_U = 3'b100;
  localparam logic [2:0] HALF_U = 3'b101;
endpackage

// File: rtl/rr_select2.sv
// rr_select2: two-way round-robin pick; on contention the port not granted last wins.
module rr_select2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  port_t      last,
  output port_t      winner,
  output logic       valid
);
  assign valid  = |req;
  assign winner = &req ? ~last : req[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin memory arbiter; MEM_ARB_TIMEOUT_EN enables the ACCESS watchdog.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [2:0]        width_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              err_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic [2:0]        width_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              err_1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_width,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_core
);
  state_t state, state_nx;
  port_t last, sel, winner;
  logic win_valid, grant, done, timeout, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [2:0] width_q;
  rr_select2 u_rr (
    .req    ({req_1, req_0}),
    .last   (last),
    .winner (winner),
    .valid  (win_valid)
  );
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || grant) ? '0 : (state == ACCESS ? cnt + 1'b1 : cnt);
  assign timeout = state == ACCESS && !mem_ready && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign timeout = 1'b0;
`endif
  // A grant during reset would be lost, so reset masks it.
  assign grant = state == IDLE && win_valid && !reset;
  assign done  = state == ACCESS && (mem_ready || timeout);
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      sel     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last    <= winner;
        sel     <= winner;
        we_q    <= winner ? we_1 : we_0;
        addr_q  <= winner ? addr_1 : addr_0;
        wdata_q <= winner ? wdata_1 : wdata_0;
        width_q <= winner ? width_1 : width_0;
        err_q   <= 1'b0;
      end
      if (done) begin
        rdata_q <= (we_q || timeout) ? '0 : mem_rdata;
        err_q   <= timeout;
      end
    end
  end
  always_comb begin
    state_nx   = state == IDLE ? (grant ? ACCESS : IDLE) : state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
    gnt_0      = grant && !winner;
    gnt_1      = grant && winner;
    mem_req    = state == ACCESS;
    mem_we     = state == ACCESS && we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_width  = width_q;
    rvalid_0   = state == RESP && !sel;
    rvalid_1   = state == RESP && sel;
    rdata_0    = rvalid_0 ? rdata_q : '0;
    rdata_1    = rvalid_1 ? rdata_q : '0;
    err_0      = rvalid_0 && err_q;
    err_1      = rvalid_1 && err_q;
    stall_core = req_0 && !rvalid_0;
  end
endmodule
